// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweeper.
// Row r = {in1,in2,in3} maps to truth-table code bit 7-r (row 000 is the MSB).
package tt_sweep_pkg;

  localparam int N_ROWS = 8;
  localparam int TT_W   = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  function automatic logic [2:0] row_to_bit(input logic [2:0] r);
    return 3'd7 - r;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter; load wins over decrement, holds at zero.
// expire is high while the count sits at 1, i.e. in the last settle cycle.
module settle_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] value,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign value  = cnt;
  assign expire = (cnt == CNT_W'(1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Steps a 3-input gate through all 8 input rows, samples it after a settle delay and
// compares the measured truth table against the expected code; done at cycle 8(S+2)+1.
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [TT_W-1:0] expected_tt,
  output logic [2:0]      dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [TT_W-1:0] captured_tt,
  output logic [TT_W-1:0] mismatch
);

  state_t            state;
  logic [2:0]        row;
  logic [TT_W-1:0]   exp_q;
  logic [TT_W-1:0]   cap_next;
  logic [CNT_W-1:0]  tmr_value;
  logic              tmr_expire;
  logic              settle_end;

  settle_timer #(.CNT_W(CNT_W)) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == APPLY),
    .load_val (CNT_W'(SETTLE_CYCLES)),
    .dec      (state == SETTLE),
    .value    (tmr_value),
    .expire   (tmr_expire)
  );

  // A zero count in SETTLE can only come from a bad load; leave rather than hang.
  assign settle_end = tmr_expire || (tmr_value == '0);

  always_comb begin
    cap_next = captured_tt;
    cap_next[row_to_bit(row)] = dut_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      row         <= 3'd0;
      exp_q       <= '0;
      dut_in      <= 3'd0;
      captured_tt <= '0;
      mismatch    <= '0;
      pass        <= 1'b0;
    end else if (state == IDLE) begin
      if (start && !abort) begin
        state       <= APPLY;
        exp_q       <= expected_tt;
        captured_tt <= '0;
        mismatch    <= '0;
        pass        <= 1'b0;
        row         <= 3'd0;
        dut_in      <= 3'd0;
      end
    end else if (abort) begin
      state <= IDLE;
      pass  <= 1'b0;
    end else begin
      case (state)
        APPLY:  state <= (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
        SETTLE: if (settle_end) state <= SAMPLE;
        SAMPLE: begin
          captured_tt <= cap_next;
          if (row == 3'd7) begin
            // Result is registered here so pass/mismatch are valid in the DONE cycle.
            state    <= DONE;
            mismatch <= cap_next ^ exp_q;
            pass     <= (cap_next == exp_q);
          end else begin
            row    <= row + 3'd1;
            dut_in <= row + 3'd1;
            state  <= APPLY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == APPLY) || (state == SETTLE) || (state == SAMPLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: a m0x8C gate on the S=4 instance, a stuck-at-1 output on the S=0 instance.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] expected_tt = 8'h00;

  logic [2:0] dut_in4, dut_in0;
  logic       dut_out4, dut_out0;
  logic       busy4, busy0, done4, done0, pass4, pass0;
  logic [7:0] cap4, cap0, mm4, mm0;

  logic [7:0] gate_code = 8'h8C;
  logic [2:0] gidx;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always_comb begin
    gidx     = 3'd7 - dut_in4;
    dut_out4 = gate_code[gidx];
    dut_out0 = 1'b1;
  end

  truth_table_sweeper #(.SETTLE_CYCLES(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected_tt(expected_tt),
    .dut_in(dut_in4), .dut_out(dut_out4), .busy(busy4), .done(done4), .pass(pass4),
    .captured_tt(cap4), .mismatch(mm4)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected_tt(expected_tt),
    .dut_in(dut_in0), .dut_out(dut_out0), .busy(busy0), .done(done0), .pass(pass0),
    .captured_tt(cap0), .mismatch(mm0)
  );

  // Accepts start at edge 0 and returns at the negedge inside cycle 1.
  task automatic kick(input logic [7:0] exp);
    @(negedge clk);
    expected_tt = exp;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // From cycle 1, observe the S=4 instance for 70 cycles: first done cycle and pulse count.
  task automatic watch4(output int done_cyc, output int pulses);
    done_cyc = 0;
    pulses = 0;
    for (int c = 1; c <= 70; c++) begin
      if (done4) begin
        pulses++;
        if (done_cyc == 0) done_cyc = c;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({dut_in4, busy4, done4, pass4, cap4, mm4} !== {3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_state: got dut_in=%0d busy=%b done=%b pass=%b cap=%h mm=%h, want all zero",
               dut_in4, busy4, done4, pass4, cap4, mm4);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy4 !== 1'b0 || busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy: got %b/%b want 0/0", busy4, busy0);
    end
  endtask

  task automatic test_pass_sweep;
    int done_cyc = 0;
    int pulses = 0;
    kick(8'h8C);
    for (int c = 1; c <= 70; c++) begin
      if (((c - 1) % 6) == 0 && c <= 43) begin
        n_cmp++;
        if (dut_in4 !== 3'((c - 1) / 6)) begin
          n_fail++;
          $display("FAIL dut_in_step cycle %0d: got %0d want %0d", c, dut_in4, (c - 1) / 6);
        end
      end
      if (c == 1 || c == 48) begin
        n_cmp++;
        if (busy4 !== 1'b1) begin
          n_fail++;
          $display("FAIL busy_high cycle %0d: got %b want 1", c, busy4);
        end
      end
      if (c == 49) begin
        n_cmp++;
        if (busy4 !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_low_done cycle 49: got %b want 0", busy4);
        end
        n_cmp++;
        if (pass4 !== 1'b1 || mm4 !== 8'h00) begin
          n_fail++;
          $display("FAIL pass_at_done: got pass=%b mm=%h want 1/00", pass4, mm4);
        end
      end
      if (done4) begin
        pulses++;
        if (done_cyc == 0) done_cyc = c;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (done_cyc != 49 || pulses != 1) begin
      n_fail++;
      $display("FAIL pass_done_timing: got cycle %0d pulses %0d want 49 / 1", done_cyc, pulses);
    end
    n_cmp++;
    if (cap4 !== 8'h8C || pass4 !== 1'b1 || mm4 !== 8'h00) begin
      n_fail++;
      $display("FAIL pass_result: got cap=%h pass=%b mm=%h want 8c/1/00", cap4, pass4, mm4);
    end
    n_cmp++;
    if (dut_in4 !== 3'd7) begin
      n_fail++;
      $display("FAIL dut_in_hold: got %0d want 7", dut_in4);
    end
  endtask

  task automatic test_mismatch;
    int done_cyc;
    int pulses;
    kick(8'h8D);
    watch4(done_cyc, pulses);
    n_cmp++;
    if (done_cyc != 49) begin
      n_fail++;
      $display("FAIL mismatch_done_timing: got %0d want 49", done_cyc);
    end
    n_cmp++;
    if (cap4 !== 8'h8C || pass4 !== 1'b0 || mm4 !== 8'h01) begin
      n_fail++;
      $display("FAIL mismatch_result: got cap=%h pass=%b mm=%h want 8c/0/01", cap4, pass4, mm4);
    end
  endtask

  task automatic test_stuck_s0;
    int done_cyc = 0;
    kick(8'h8C);
    for (int c = 1; c <= 70; c++) begin
      if (done0 && done_cyc == 0) done_cyc = c;
      @(negedge clk);
    end
    n_cmp++;
    if (done_cyc != 17) begin
      n_fail++;
      $display("FAIL stuck_done_timing: got %0d want 17", done_cyc);
    end
    n_cmp++;
    if (cap0 !== 8'hFF || mm0 !== 8'h73 || pass0 !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck_result: got cap=%h mm=%h pass=%b want ff/73/0", cap0, mm0, pass0);
    end
  endtask

  task automatic test_abort;
    int pulses = 0;
    kick(8'h8C);
    for (int c = 1; c <= 70; c++) begin
      abort = (c == 20);
      if (c == 21) begin
        n_cmp++;
        if (busy4 !== 1'b0) begin
          n_fail++;
          $display("FAIL abort_busy cycle 21: got %b want 0", busy4);
        end
      end
      if (done4) pulses++;
      @(negedge clk);
    end
    abort = 1'b0;
    n_cmp++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d pulses want 0", pulses);
    end
    n_cmp++;
    if (cap4 !== 8'h80 || pass4 !== 1'b0 || mm4 !== 8'h00 || dut_in4 !== 3'd3) begin
      n_fail++;
      $display("FAIL abort_state: got cap=%h pass=%b mm=%h dut_in=%0d want 80/0/00/3",
               cap4, pass4, mm4, dut_in4);
    end
  endtask

  task automatic test_back_to_back;
    int done_cyc = 0;
    int busy_seen = 0;
    kick(8'h8C);
    for (int c = 1; c <= 70; c++) begin
      start = (c == 10);
      if (done4 && done_cyc == 0) done_cyc = c;
      @(negedge clk);
    end
    start = 1'b0;
    n_cmp++;
    if (done_cyc != 49 || pass4 !== 1'b1) begin
      n_fail++;
      $display("FAIL midsweep_start: got done cycle %0d pass=%b want 49/1", done_cyc, pass4);
    end
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (busy4 || busy0 || done4) busy_seen++;
      @(negedge clk);
    end
    n_cmp++;
    if (busy_seen != 0) begin
      n_fail++;
      $display("FAIL start_abort_idle: got %0d active cycles want 0", busy_seen);
    end
  endtask

  task automatic test_reset_mid;
    int done_cyc;
    int pulses;
    kick(8'h8C);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({dut_in4, busy4, done4, pass4, cap4, mm4} !== {3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_mid: got dut_in=%0d busy=%b done=%b pass=%b cap=%h mm=%h want all zero",
               dut_in4, busy4, done4, pass4, cap4, mm4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    kick(8'h8C);
    watch4(done_cyc, pulses);
    n_cmp++;
    if (done_cyc != 49 || cap4 !== 8'h8C || pass4 !== 1'b1 || mm4 !== 8'h00) begin
      n_fail++;
      $display("FAIL after_reset_sweep: got done=%0d cap=%h pass=%b mm=%h want 49/8c/1/00",
               done_cyc, cap4, pass4, mm4);
    end
  endtask

  initial begin
    test_reset();
    test_pass_sweep();
    test_mismatch();
    test_stuck_s0();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
